// File: rtl/mem_pkg.sv
// Shared types for the banked-memory arbiter: lane vector, request bundle
// and the arbiter FSM states.
package mem_pkg;

  localparam int ADDR_W = 18;
  localparam int LANES  = 16;
  localparam int DATA_W = 16;

  // Highest base address a vector access may use without lane wrap.
  localparam logic [ADDR_W:0] VEC_MAX =
    (ADDR_W+1)'((1 << ADDR_W) - LANES);

  typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic              wren;
    logic              vec;
    logic [ADDR_W-1:0] addr;
    lane_vec_t         data;
  } mem_req_t;

  function automatic logic vec_oob(
    input logic              vec,
    input logic [ADDR_W-1:0] addr
  );
    return vec && ({1'b0, addr} > VEC_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester after
// the last granted one; the pointer moves only when advance is strobed.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant  = '0;
    last_d = last_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        if (advance) last_d = idx;
      end
    end
  end

  // Reset to the last index so requester 0 is first in line.
  always_ff @(posedge clk) begin
    if (rst) last_q <= IDX_W'(NUM_REQ - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the banked memory controller between NUM_REQ requesters with one
// access outstanding; returns read data or write-done/error to the issuer.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_wren,
  input  logic [NUM_REQ-1:0]            req_vec,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  lane_vec_t [NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_err,
  output lane_vec_t                     rsp_data,
  output logic [ADDR_W-1:0]             mem_address,
  output lane_vec_t                     mem_data,
  output logic                          mem_wren,
  output logic                          mem_vec_scalar,
  input  lane_vec_t                     mem_q
);

  localparam int ID_W  = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  arb_state_t          state_q, state_d;
  mem_req_t            req_q, req_d, sel;
  logic [ID_W-1:0]     id_q, id_d, sel_id;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wren_q, wren_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  lane_vec_t           rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]  arb_valid, grant, id_oh;
  logic                advance;

  assign arb_valid = (state_q == IDLE) ? req_valid : '0;
  assign advance   = |grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .valid   (arb_valid),
    .advance (advance),
    .grant   (grant)
  );

  always_comb begin
    sel    = '0;
    sel_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel.wren = req_wren[i];
        sel.vec  = req_vec[i];
        sel.addr = req_addr[i];
        sel.data = req_data[i];
        sel_id   = ID_W'(i);
      end
    end
  end

  always_comb begin
    id_oh       = '0;
    id_oh[id_q] = 1'b1;
    state_d     = state_q;
    req_d       = req_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    wren_d      = 1'b0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      IDLE: begin
        if (advance) begin
          req_d = sel;
          id_d  = sel_id;
          if (vec_oob(sel.vec, sel.addr)) begin
            state_d     = RESP;
            rsp_valid_d = grant;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
            wren_d  = sel.wren;
          end
        end
      end
      ISSUE: begin
        if (req_q.wren) begin
          state_d     = RESP;
          rsp_valid_d = id_oh;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = id_oh;
          if (req_q.vec) begin
            rsp_data_d = mem_q;
          end else begin
            rsp_data_d    = '0;
            rsp_data_d[0] = mem_q[0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      wren_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      wren_q      <= wren_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready      = grant;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_data       = rsp_data_q;
  assign mem_address    = req_q.addr;
  assign mem_data       = req_q.data;
  assign mem_vec_scalar = req_q.vec;
  assign mem_wren       = wren_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Random and directed traffic from two requesters against a memory model,
// with a response scoreboard fed at each handshake.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int N      = 2;
  localparam int RD_LAT = 1;
  localparam int AMASK  = (1 << ADDR_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready, req_wren, req_vec, rsp_valid;
  logic [N-1:0][ADDR_W-1:0] req_addr;
  lane_vec_t [N-1:0] req_data;
  logic rsp_err, mem_wren, mem_vec_scalar;
  lane_vec_t rsp_data, mem_data, mem_q;
  logic [ADDR_W-1:0] mem_address;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(N), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wren(req_wren), .req_vec(req_vec),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_vec_scalar(mem_vec_scalar),
    .mem_q(mem_q)
  );

  function automatic logic [15:0] init_val(input int a);
    return 16'(a) ^ 16'h5A5A;
  endfunction

  // RAM stores data XOR its default so a zeroed array means "untouched".
  bit [15:0] ram [0:AMASK];
  lane_vec_t q_pipe [RD_LAT];
  assign mem_q = q_pipe[RD_LAT-1];

  always @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      int a;
      a = (int'(mem_address) + i) & AMASK;
      if (mem_wren && (mem_vec_scalar || i == 0))
        ram[a] <= mem_data[i] ^ init_val(a);
      q_pipe[0][i] <= ram[a] ^ init_val(a);
    end
    for (int s = 1; s < RD_LAT; s++) q_pipe[s] <= q_pipe[s-1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int        id;
    bit        err;
    bit        rd;
    lane_vec_t data;
    int        cyc;
    int        wren0;
    int        nw;
  } exp_t;

  exp_t exp_q[$];
  bit   grant_log[$];
  logic [15:0] ref_mem [int];
  lane_vec_t last_rd;
  int ref_last;
  int wren_cnt;
  int n_chk, n_fail;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic on_handshake();
    int   w, ew, lat;
    exp_t e;
    logic [ADDR_W-1:0] a;
    w  = 0;
    ew = -1;
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) w = i;
    for (int k = 1; k <= N; k++)
      if (ew < 0 && req_valid[(ref_last + k) % N]) ew = (ref_last + k) % N;
    chk("rr_grant", 256'(req_ready), 256'(1 << ew));
    ref_last = w;
    grant_log.push_back(w[0]);
    a     = req_addr[w];
    e.id  = w;
    e.err = req_vec[w] && (int'(a) > (1 << ADDR_W) - LANES);
    e.rd  = !req_wren[w] && !e.err;
    e.nw  = (req_wren[w] && !e.err) ? 1 : 0;
    lat   = e.err ? 1 : (req_wren[w] ? 2 : 2 + RD_LAT);
    e.cyc = cyc + lat;
    e.wren0 = wren_cnt;
    e.data  = '0;
    for (int i = 0; i < LANES; i++) begin
      int la;
      la = (int'(a) + i) & AMASK;
      if (req_vec[w] || i == 0) begin
        if (e.nw == 1) ref_mem[la] = req_data[w][i];
        if (e.rd) e.data[i] = ref_rd(la);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic on_response();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_rsp: got rsp_valid=%b expected none",
               rsp_valid);
      return;
    end
    e = exp_q.pop_front();
    chk("rsp_id", 256'(rsp_valid), 256'(1 << e.id));
    chk("rsp_err", 256'(rsp_err), 256'(e.err));
    chk("rsp_latency", 256'(cyc), 256'(e.cyc));
    chk("wren_cycles", 256'(wren_cnt - e.wren0), 256'(e.nw));
    if (e.rd) begin
      chk("rsp_data", rsp_data, e.data);
      last_rd = e.data;
    end else begin
      chk("rsp_data_hold", rsp_data, last_rd);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mem_wren) wren_cnt++;
      if (!rst) begin
        chk("ready_onehot0", 256'($onehot0(req_ready)), 256'(1));
        if (|rsp_valid) on_response();
        if (|(req_valid & req_ready)) on_handshake();
      end
    end
  endtask

  task automatic drive(input logic [0:0] id, input bit wr, input bit v,
                       input logic [ADDR_W-1:0] a, input lane_vec_t d,
                       input bit keep);
    bit got;
    got = 1'b0;
    req_wren[id]  = wr;
    req_vec[id]   = v;
    req_addr[id]  = a;
    req_data[id]  = d;
    req_valid[id] = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL hs_timeout: requester %0d got no ready", id);
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", 256'(done), 256'(1));
    @(posedge clk);
    #1;
  endtask

  function automatic lane_vec_t rnd_vec();
    lane_vec_t d;
    for (int i = 0; i < LANES; i++) d[i] = 16'($urandom);
    return d;
  endfunction

  function automatic logic [ADDR_W-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0)
      return ADDR_W'(18'h3FFE8 + $urandom_range(0, 23));
    return ADDR_W'(18'h00200 + $urandom_range(0, 63));
  endfunction

  task automatic rnd_stream(input logic [0:0] id, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      drive(id, 1'($urandom), 1'($urandom), rnd_addr(), rnd_vec(), 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    lane_vec_t d;
    logic [3:0] order;
    rst = 1'b1;
    req_valid = '0;
    req_wren = '0;
    req_vec = '0;
    req_addr = '0;
    req_data = '0;
    last_rd = '0;
    ref_last = N - 1;
    wren_cnt = 0;
    n_chk = 0;
    n_fail = 0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 256'(req_ready), 256'(0));
    chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("rst_rsp_err", 256'(rsp_err), 256'(0));
    chk("rst_rsp_data", rsp_data, 256'(0));
    chk("rst_mem_address", 256'(mem_address), 256'(0));
    chk("rst_mem_data", mem_data, 256'(0));
    chk("rst_mem_wren", 256'(mem_wren), 256'(0));
    chk("rst_mem_vec", 256'(mem_vec_scalar), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("idle_mem_wren", 256'(mem_wren), 256'(0));
      chk("idle_rsp_valid", 256'(rsp_valid), 256'(0));
    end
    @(posedge clk);
    #1;

    d = '0;
    d[0] = 16'hBEEF;
    drive(1'b0, 1'b1, 1'b0, 18'h00010, d, 1'b0);
    drain();
    drive(1'b0, 1'b0, 1'b0, 18'h00010, rnd_vec(), 1'b0);
    drain();

    for (int i = 0; i < LANES; i++) d[i] = 16'(16'h1000 + i);
    drive(1'b1, 1'b1, 1'b1, 18'h00100, d, 1'b0);
    drain();
    drive(1'b1, 1'b0, 1'b1, 18'h00100, rnd_vec(), 1'b0);
    drain();

    grant_log.delete();
    fork
      begin
        drive(1'b0, 1'b1, 1'b0, 18'h00300, rnd_vec(), 1'b1);
        drive(1'b0, 1'b0, 1'b0, 18'h00300, rnd_vec(), 1'b0);
      end
      begin
        drive(1'b1, 1'b1, 1'b1, 18'h00310, rnd_vec(), 1'b1);
        drive(1'b1, 1'b0, 1'b1, 18'h00310, rnd_vec(), 1'b0);
      end
    join
    drain();
    chk("grant_count", 256'(grant_log.size()), 256'(4));
    order = '0;
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      order[3-i] = grant_log[i];
    chk("grant_order", 256'(order), 256'(4'b0101));

    drive(1'b1, 1'b0, 1'b1, 18'h3FFF0, rnd_vec(), 1'b0);
    drain();
    drive(1'b1, 1'b0, 1'b1, 18'h3FFF1, rnd_vec(), 1'b0);
    drain();
    drive(1'b0, 1'b0, 1'b0, 18'h3FFFF, rnd_vec(), 1'b0);
    drain();

    drive(1'b0, 1'b0, 1'b1, 18'h00100, rnd_vec(), 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    ref_last = N - 1;
    last_rd = '0;
    @(negedge clk);
    chk("rrst_rsp_data", rsp_data, 256'(0));
    chk("rrst_mem_wren", 256'(mem_wren), 256'(0));
    chk("rrst_req_ready", 256'(req_ready), 256'(0));
    @(posedge clk);
    #1;
    fork
      drive(1'b0, 1'b0, 1'b1, 18'h00100, rnd_vec(), 1'b0);
      drive(1'b1, 1'b0, 1'b0, 18'h00010, rnd_vec(), 1'b0);
      begin
        @(negedge clk);
        chk("rrst_first_grant", 256'(req_ready), 256'(2'b01));
      end
    join
    drain();

    fork
      rnd_stream(1'b0, 20);
      rnd_stream(1'b1, 20);
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
